// File: rtl/des_cbc_if.sv
`timescale 1ns/1ps
// Host stream and DES-core signals of the CBC controller.
// The controller uses the master modport, and the host/core environment uses the slave modport.
interface des_cbc_if;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] core_data;
  logic        core_data_en;
  logic [63:0] core_key;
  logic        core_mode;
  logic        core_key_en;
  logic [63:0] core_result;
  logic        core_busy;
  logic        core_wr;

  // valid/ready: a transfer completes on a clk_en cycle where valid and ready are both 1;
  // while valid=1 and ready=0 the sender holds its data stable.
  modport master (
    input  in_data, in_valid, out_ready, core_result, core_busy, core_wr,
    output in_ready, out_data, out_valid, core_data, core_data_en,
           core_key, core_mode, core_key_en
  );
  modport slave (
    output in_data, in_valid, out_ready, core_result, core_busy, core_wr,
    input  in_ready, out_data, out_valid, core_data, core_data_en,
           core_key, core_mode, core_key_en
  );
endinterface

// File: rtl/des_cbc_ctrl.sv
`timescale 1ns/1ps
// CBC controller for a single-round-per-cycle DES core. WAIT_LIMIT must be at least 18.
// Defining DES_CBC_ECB_EN adds the cfg_ecb input, which bypasses the chaining.
module des_cbc_ctrl #(
  parameter logic [63:0] IV_RESET   = 64'h0,
  parameter int          WAIT_LIMIT = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [63:0] cfg_key,
  input  logic [63:0] cfg_iv,
  input  logic        cfg_dec,
  input  logic        cfg_en,
`ifdef DES_CBC_ECB_EN
  input  logic        cfg_ecb,
`endif
  output logic        cfg_busy,
  des_cbc_if.master   bus,
  output logic        core_err,
  output logic [2:0]  dbg_state
);
  typedef enum logic [2:0] {
    UNCFG = 3'd0, KEY = 3'd1, READY = 3'd2, ISSUE = 3'd3, WAIT = 3'd4, HOLD = 3'd5
  } state_t;

  localparam int WD_W = $clog2(WAIT_LIMIT);

  state_t      state;
  logic        key_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic [63:0] key_r, chain, cur, core_data_r, out_data_r;
  logic        dec_r, ecb_r;
  logic        in_ready_r, out_valid_r, core_data_en_r, core_key_en_r, cfg_busy_r, core_err_r;
  logic        cfg_acc, in_acc;

  // An input handshake in READY takes precedence over a simultaneous cfg_en,
  // because the host already sees that transfer as complete.
  assign in_acc  = (state == READY) && bus.in_valid;
  assign cfg_acc = cfg_en && ((state == UNCFG) || ((state == READY) && !bus.in_valid));

`ifdef DES_CBC_ECB_EN
  always_ff @(posedge clk) begin
    if (!rst)                    ecb_r <= 1'b0;
    else if (clk_en && cfg_acc)  ecb_r <= cfg_ecb;
  end
`else
  assign ecb_r = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= UNCFG;
      key_cnt        <= 1'b0;
      wd_cnt         <= '0;
      key_r          <= '0;
      dec_r          <= 1'b0;
      chain          <= IV_RESET;
      cur            <= '0;
      core_data_r    <= '0;
      out_data_r     <= '0;
      in_ready_r     <= 1'b0;
      out_valid_r    <= 1'b0;
      core_data_en_r <= 1'b0;
      core_key_en_r  <= 1'b0;
      cfg_busy_r     <= 1'b0;
      core_err_r     <= 1'b0;
    end else if (clk_en) begin
      core_key_en_r <= 1'b0;
      if (cfg_acc) begin
        key_r         <= cfg_key;
        dec_r         <= cfg_dec;
        chain         <= cfg_iv;
        core_key_en_r <= 1'b1;
        cfg_busy_r    <= 1'b1;
        in_ready_r    <= 1'b0;
        key_cnt       <= 1'b0;
        state         <= KEY;
      end else begin
        case (state)
          UNCFG: ;
          KEY: begin
            if (key_cnt) begin
              in_ready_r <= 1'b1;
              cfg_busy_r <= 1'b0;
              state      <= READY;
            end else begin
              key_cnt <= 1'b1;
            end
          end
          READY: begin
            if (in_acc) begin
              cur            <= bus.in_data;
              core_data_r    <= (dec_r || ecb_r) ? bus.in_data : (bus.in_data ^ chain);
              core_data_en_r <= !bus.core_busy;
              in_ready_r     <= 1'b0;
              cfg_busy_r     <= 1'b1;
              state          <= ISSUE;
            end
          end
          // core_data_en is decided one cycle ahead so that it stays a registered output
          ISSUE: begin
            if (core_data_en_r) begin
              core_data_en_r <= 1'b0;
              wd_cnt         <= '0;
              state          <= WAIT;
            end else if (!bus.core_busy) begin
              core_data_en_r <= 1'b1;
            end
          end
          WAIT: begin
            if (bus.core_wr) begin
              out_valid_r <= 1'b1;
              state       <= HOLD;
              if (ecb_r) begin
                out_data_r <= bus.core_result;
              end else if (dec_r) begin
                out_data_r <= bus.core_result ^ chain;
                chain      <= cur;
              end else begin
                out_data_r <= bus.core_result;
                chain      <= bus.core_result;
              end
            end else if (wd_cnt == WD_W'(WAIT_LIMIT - 1)) begin
              core_err_r <= 1'b1;
              cfg_busy_r <= 1'b0;
              state      <= UNCFG;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
          HOLD: begin
            if (bus.out_ready) begin
              out_valid_r <= 1'b0;
              in_ready_r  <= 1'b1;
              cfg_busy_r  <= 1'b0;
              state       <= READY;
            end
          end
          default: state <= UNCFG;
        endcase
      end
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.out_data     = out_data_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.core_data    = core_data_r;
  assign bus.core_data_en = core_data_en_r;
  assign bus.core_key     = key_r;
  assign bus.core_mode    = dec_r;
  assign bus.core_key_en  = core_key_en_r;
  assign cfg_busy         = cfg_busy_r;
  assign core_err         = core_err_r;
  assign dbg_state        = state;
endmodule

// File: tb/tb_des_cbc_ctrl.sv
`timescale 1ns/1ps
// Directed bench for des_cbc_ctrl. The DES core is emulated by hand-supplied core_result values.
module tb_des_cbc_ctrl;
  localparam logic [2:0] S_UNCFG = 3'd0, S_KEY = 3'd1, S_READY = 3'd2,
                         S_ISSUE = 3'd3, S_WAIT = 3'd4, S_HOLD = 3'd5;
  localparam logic [63:0] K    = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT   = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT   = 64'h85E813540F0AB405;
  localparam logic [63:0] PTX  = 64'h84CB563386A179EA; // PT ^ CT
  localparam logic [63:0] R2   = 64'h0F1E2D3C4B5A6978;
  localparam logic [63:0] PTR2 = 64'h0E3D685BC2F1A497; // PT ^ R2
  localparam logic [63:0] Y    = 64'h1111111111111111;
  localparam logic [63:0] HR   = 64'hA5A5A5A5A5A5A5A5;

  logic        clk = 1'b0;
  logic        rst, clk_en, cfg_dec, cfg_en, cfg_ecb, cfg_busy, core_err;
  logic [63:0] cfg_key, cfg_iv;
  logic [2:0]  dbg_state;
  int checks = 0;
  int errors = 0;

  des_cbc_if bus();

  des_cbc_ctrl #(.IV_RESET(64'h0), .WAIT_LIMIT(24)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_dec(cfg_dec), .cfg_en(cfg_en),
`ifdef DES_CBC_ECB_EN
    .cfg_ecb(cfg_ecb),
`endif
    .cfg_busy(cfg_busy), .bus(bus.master), .core_err(core_err), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL sim_timeout got running want finished");
    $fatal(1);
  end

  // driver tasks: inputs change 1 ns after the rising edge, checks follow at that point
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic configure(input logic [63:0] key, input logic [63:0] iv, input logic dec);
    cfg_key = key; cfg_iv = iv; cfg_dec = dec; cfg_en = 1'b1;
    tick();
    cfg_en = 1'b0;
    tick(); tick();
  endtask

  task automatic send_block(input logic [63:0] d);
    bus.in_data = d; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic core_reply(input logic [63:0] r, input int delay);
    tick();
    repeat (delay) tick();
    bus.core_result = r; bus.core_wr = 1'b1;
    tick();
    bus.core_wr = 1'b0;
  endtask

  task automatic take_output();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; clk_en = 1'b1; cfg_key = '0; cfg_iv = '0; cfg_dec = 1'b0; cfg_en = 1'b0;
    cfg_ecb = 1'b0; bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.core_result = '0; bus.core_busy = 1'b0; bus.core_wr = 1'b0;
    tick(); tick();
    checks++; if (dbg_state !== S_UNCFG) begin errors++; $display("FAIL rst_state got %0d want %0d", dbg_state, S_UNCFG); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 64'h0) begin errors++; $display("FAIL rst_out_data got %h want 0", bus.out_data); end
    checks++; if (bus.core_data_en !== 1'b0 || bus.core_key_en !== 1'b0) begin errors++; $display("FAIL rst_core_en got %b%b want 00", bus.core_data_en, bus.core_key_en); end
    checks++; if (core_err !== 1'b0 || cfg_busy !== 1'b0) begin errors++; $display("FAIL rst_err_busy got %b%b want 00", core_err, cfg_busy); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_encrypt();
    configure(K, 64'h0, 1'b0);
    checks++; if (dbg_state !== S_READY || bus.in_ready !== 1'b1) begin errors++; $display("FAIL enc_cfg_ready got %0d/%b want %0d/1", dbg_state, bus.in_ready, S_READY); end
    checks++; if (bus.core_key !== K || bus.core_mode !== 1'b0) begin errors++; $display("FAIL enc_core_key got %h/%b want %h/0", bus.core_key, bus.core_mode, K); end
    send_block(PT);
    checks++; if (bus.core_data !== PT) begin errors++; $display("FAIL enc1_core_data got %h want %h", bus.core_data, PT); end
    checks++; if (bus.core_data_en !== 1'b1 || dbg_state !== S_ISSUE) begin errors++; $display("FAIL enc1_issue got %b/%0d want 1/%0d", bus.core_data_en, dbg_state, S_ISSUE); end
    core_reply(CT, 3);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== CT) begin errors++; $display("FAIL enc1_out got %b/%h want 1/%h", bus.out_valid, bus.out_data, CT); end
    take_output();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL enc1_release got %b/%b want 1/0", bus.in_ready, bus.out_valid); end
    send_block(PT);
    checks++; if (bus.core_data !== PTX) begin errors++; $display("FAIL enc2_core_data got %h want %h", bus.core_data, PTX); end
    core_reply(R2, 1);
    checks++; if (bus.out_data !== R2) begin errors++; $display("FAIL enc2_out got %h want %h", bus.out_data, R2); end
    take_output();
    // a stray core_wr outside WAIT must not disturb the chain
    bus.core_result = 64'hDEADBEEFDEADBEEF; bus.core_wr = 1'b1;
    tick();
    bus.core_wr = 1'b0;
    send_block(PT);
    checks++; if (bus.core_data !== PTR2) begin errors++; $display("FAIL enc3_chain got %h want %h", bus.core_data, PTR2); end
    core_reply(CT, 0);
    take_output();
  endtask

  task automatic test_decrypt();
    configure(K, 64'h0, 1'b1);
    checks++; if (bus.core_mode !== 1'b1) begin errors++; $display("FAIL dec_mode got %b want 1", bus.core_mode); end
    bus.core_busy = 1'b1;
    send_block(CT);
    checks++; if (bus.core_data !== CT || bus.core_data_en !== 1'b0) begin errors++; $display("FAIL dec_busy_issue got %h/%b want %h/0", bus.core_data, bus.core_data_en, CT); end
    tick();
    checks++; if (bus.core_data_en !== 1'b0 || dbg_state !== S_ISSUE) begin errors++; $display("FAIL dec_busy_hold got %b/%0d want 0/%0d", bus.core_data_en, dbg_state, S_ISSUE); end
    bus.core_busy = 1'b0;
    tick();
    checks++; if (bus.core_data_en !== 1'b1) begin errors++; $display("FAIL dec_issue_after_busy got %b want 1", bus.core_data_en); end
    core_reply(PT, 2);
    checks++; if (bus.out_data !== PT) begin errors++; $display("FAIL dec1_out got %h want %h", bus.out_data, PT); end
    take_output();
    send_block(Y);
    checks++; if (bus.core_data !== Y) begin errors++; $display("FAIL dec2_core_data got %h want %h", bus.core_data, Y); end
    core_reply(PT, 0);
    checks++; if (bus.out_data !== PTX) begin errors++; $display("FAIL dec2_out got %h want %h", bus.out_data, PTX); end
    take_output();
  endtask

  task automatic test_hold();
    configure(K, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    send_block(64'h0);
    checks++; if (bus.core_data !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL hold_iv_xor got %h want ffffffffffffffff", bus.core_data); end
    core_reply(HR, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin cfg_key = 64'h0; cfg_dec = 1'b1; cfg_en = 1'b1; end
      tick();
      cfg_en = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== HR) begin errors++; $display("FAIL hold_out_%0d got %b/%h want 1/%h", i, bus.out_valid, bus.out_data, HR); end
      checks++; if (bus.in_ready !== 1'b0 || cfg_busy !== 1'b1 || dbg_state !== S_HOLD) begin errors++; $display("FAIL hold_flags_%0d got %b/%b/%0d want 0/1/%0d", i, bus.in_ready, cfg_busy, dbg_state, S_HOLD); end
    end
    checks++; if (bus.core_key !== K || bus.core_mode !== 1'b0 || bus.core_key_en !== 1'b0) begin errors++; $display("FAIL hold_cfg_ignored got %h/%b/%b want %h/0/0", bus.core_key, bus.core_mode, bus.core_key_en, K); end
    take_output();
    checks++; if (dbg_state !== S_READY || bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got %0d/%b want %0d/1", dbg_state, bus.in_ready, S_READY); end
  endtask

  task automatic test_timeout();
    configure(K, 64'h0, 1'b0);
    send_block(PT);
    tick();
    repeat (23) tick();
    checks++; if (core_err !== 1'b0 || dbg_state !== S_WAIT) begin errors++; $display("FAIL tmo_early got %b/%0d want 0/%0d", core_err, dbg_state, S_WAIT); end
    tick();
    checks++; if (core_err !== 1'b1 || dbg_state !== S_UNCFG) begin errors++; $display("FAIL tmo_flag got %b/%0d want 1/%0d", core_err, dbg_state, S_UNCFG); end
    checks++; if (bus.out_valid !== 1'b0 || cfg_busy !== 1'b0) begin errors++; $display("FAIL tmo_no_out got %b/%b want 0/0", bus.out_valid, cfg_busy); end
    bus.core_result = CT; bus.core_wr = 1'b1;
    tick();
    bus.core_wr = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || dbg_state !== S_UNCFG) begin errors++; $display("FAIL tmo_late_wr got %b/%0d want 0/%0d", bus.out_valid, dbg_state, S_UNCFG); end
    configure(K, 64'h0, 1'b0);
    checks++; if (core_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b want 1", core_err); end
  endtask

  task automatic test_reset_mid_and_clk_en();
    send_block(PT);
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (dbg_state !== S_UNCFG || core_err !== 1'b0 || cfg_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_state got %0d/%b/%b want %0d/0/0", dbg_state, core_err, cfg_busy, S_UNCFG); end
    checks++; if (bus.out_data !== 64'h0 || bus.in_ready !== 1'b0 || bus.core_data_en !== 1'b0) begin errors++; $display("FAIL mid_rst_outs got %h/%b/%b want 0/0/0", bus.out_data, bus.in_ready, bus.core_data_en); end
    rst = 1'b1; bus.core_result = CT; bus.core_wr = 1'b1;
    tick();
    bus.core_wr = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_discard got %b want 0", bus.out_valid); end
    cfg_key = K; cfg_iv = 64'h0; cfg_dec = 1'b0; cfg_en = 1'b1;
    tick();
    cfg_en = 1'b0;
    checks++; if (dbg_state !== S_KEY || bus.core_key_en !== 1'b1) begin errors++; $display("FAIL key_enter got %0d/%b want %0d/1", dbg_state, bus.core_key_en, S_KEY); end
    clk_en = 1'b0;
    repeat (5) tick();
    checks++; if (dbg_state !== S_KEY || bus.core_key_en !== 1'b1 || cfg_busy !== 1'b1) begin errors++; $display("FAIL key_frozen got %0d/%b/%b want %0d/1/1", dbg_state, bus.core_key_en, cfg_busy, S_KEY); end
    clk_en = 1'b1;
    tick();
    checks++; if (dbg_state !== S_KEY || bus.core_key_en !== 1'b0) begin errors++; $display("FAIL key_second got %0d/%b want %0d/0", dbg_state, bus.core_key_en, S_KEY); end
    tick();
    checks++; if (dbg_state !== S_READY || bus.in_ready !== 1'b1) begin errors++; $display("FAIL key_done got %0d/%b want %0d/1", dbg_state, bus.in_ready, S_READY); end
    clk_en = 1'b0; bus.in_data = PT; bus.in_valid = 1'b1;
    repeat (3) tick();
    checks++; if (dbg_state !== S_READY) begin errors++; $display("FAIL gated_handshake got %0d want %0d", dbg_state, S_READY); end
    clk_en = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (dbg_state !== S_ISSUE || bus.core_data !== PT) begin errors++; $display("FAIL enabled_handshake got %0d/%h want %0d/%h", dbg_state, bus.core_data, S_ISSUE, PT); end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_hold();
    test_timeout();
    test_reset_mid_and_clk_en();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
